// File: rtl/output_port_alloc_pkg.sv
// Shared constants and types for the output port allocator.
// Direction indices follow the router port order IP/W/E/S/N/D/U.
// Optional feature macro: ARB_FIXED_PRIO_EN (fixed-priority arbitration).
package output_port_alloc_pkg;

    // Router radix; also the width of each input's forward-direction vector
    localparam int unsigned RADIX = 7;

    localparam int unsigned IDX_IP = 0;
    localparam int unsigned IDX_W  = 1;
    localparam int unsigned IDX_E  = 2;
    localparam int unsigned IDX_S  = 3;
    localparam int unsigned IDX_N  = 4;
    localparam int unsigned IDX_D  = 5;
    localparam int unsigned IDX_U  = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/output_port_alloc_rr_priority_pick.sv
// Combinational rotating-priority picker: returns the first set request
// found when searching upward from ptr+1, wrapping modulo N_IN.
// Passing ptr = N_IN-1 yields plain lowest-index priority.
module rr_priority_pick
    import output_port_alloc_pkg::*;
#(
    parameter int unsigned N_IN  = RADIX,
    parameter int unsigned SEL_W = 3
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_IN-1:0]  win,
    output logic [SEL_W-1:0] win_idx,
    output logic             any
);

    // Search N_IN positions starting just after the pointer; first hit wins
    always_comb begin
        int unsigned idx;
        logic        found;
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 1; k <= N_IN; k++) begin
            idx = (32'(ptr) + k) % N_IN;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                win_idx  = SEL_W'(idx);
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/output_port_alloc.sv
// Per-output-port wormhole switch allocator for one 3D-mesh router output.
// Arbitrates among inputs whose routed direction selects this output,
// locks the winner until its tail flit transfers, and drives FIFO pops
// and the crossbar select.
// Optional feature macro: ARB_FIXED_PRIO_EN -- when defined, the idle
// winner is the lowest-index requester and the round-robin pointer is removed.
module output_port_alloc
    import output_port_alloc_pkg::*;
#(
    parameter int unsigned OUT_IDX = IDX_IP,
    parameter int unsigned N_IN    = RADIX,
    parameter int unsigned SEL_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RADIX*N_IN-1:0] fwd_dir,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN-1:0]       in_tail,
    input  logic                  out_full,
    output logic [N_IN-1:0]       grant,
    output logic [N_IN-1:0]       pop,
    output logic [SEL_W-1:0]      xbar_sel,
    output logic                  out_valid,
    output logic                  busy
);

    state_t           state;
    state_t           state_nxt;
    logic [N_IN-1:0]  req;
    logic [N_IN-1:0]  win;
    logic [N_IN-1:0]  grant_nxt;
    logic [SEL_W-1:0] win_idx;
    logic [SEL_W-1:0] sel_nxt;
    logic [SEL_W-1:0] pick_ptr;
    logic             any_req;
    logic             release_lock;
    logic             unused_dir;

    // Only one bit per input's direction vector matters to this instance
    assign unused_dir = ^fwd_dir;

    // Build the request vector; an input may not turn back onto its own
    // link, except the local IP port which may loop back to itself
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            req[i] = in_valid[i] & fwd_dir[RADIX*i + OUT_IDX];
        end
        if (OUT_IDX != IDX_IP) begin
            req[OUT_IDX] = 1'b0;
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // Pointer fixed at the top index so the search always starts at input 0
    assign pick_ptr = SEL_W'(N_IN - 1);
`else
    logic [SEL_W-1:0] rr_ptr;

    // Remember the last released owner so it gets lowest priority next round
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= SEL_W'(N_IN - 1);
        end else if (release_lock) begin
            rr_ptr <= xbar_sel;
        end
    end

    assign pick_ptr = rr_ptr;
`endif

    rr_priority_pick #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any_req)
    );

    // Transfers only from the owner, only when its flit is present and the link has room
    assign pop          = grant & in_valid & {N_IN{~out_full}};
    assign out_valid    = |pop;
    assign busy         = (state == LOCKED);
    assign release_lock = |(pop & in_tail);

    // Next-state: lock onto the arbitration winner, release after the tail transfer
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = xbar_sel;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = LOCKED;
                    grant_nxt = win;
                    sel_nxt   = win_idx;
                end
            end
            LOCKED: begin
                if (release_lock) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
        endcase
    end

    // State, ownership and crossbar select registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            xbar_sel <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            xbar_sel <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_output_port_alloc.sv
// Directed bench for output_port_alloc: one instance serving E, one serving IP.
// Expected winner sequences are queued up front and consumed as pops appear.
module tb_output_port_alloc;
    import output_port_alloc_pkg::*;

    localparam int unsigned N_IN  = 7;
    localparam int unsigned SEL_W = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [RADIX*N_IN-1:0] fwd_dir;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN-1:0]       in_tail;
    logic                  out_full;

    logic [N_IN-1:0]  grant_e, pop_e, grant_p, pop_p;
    logic [SEL_W-1:0] sel_e, sel_p;
    logic             ov_e, busy_e, ov_p, busy_p;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    output_port_alloc #(
        .OUT_IDX (IDX_E),
        .N_IN    (N_IN),
        .SEL_W   (SEL_W)
    ) dut_e (
        .clk       (clk),
        .rst       (rst),
        .fwd_dir   (fwd_dir),
        .in_valid  (in_valid),
        .in_tail   (in_tail),
        .out_full  (out_full),
        .grant     (grant_e),
        .pop       (pop_e),
        .xbar_sel  (sel_e),
        .out_valid (ov_e),
        .busy      (busy_e)
    );

    output_port_alloc #(
        .OUT_IDX (IDX_IP),
        .N_IN    (N_IN),
        .SEL_W   (SEL_W)
    ) dut_p (
        .clk       (clk),
        .rst       (rst),
        .fwd_dir   (fwd_dir),
        .in_valid  (in_valid),
        .in_tail   (in_tail),
        .out_full  (out_full),
        .grant     (grant_p),
        .pop       (pop_p),
        .xbar_sel  (sel_p),
        .out_valid (ov_p),
        .busy      (busy_p)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Direction vectors: requested bit set for each input in 'who', bits 0 and 2
    // (the two observed outputs) otherwise clear, all other bits random noise
    function automatic logic [RADIX*N_IN-1:0] dirs(input logic [N_IN-1:0] who, input int unsigned b);
        logic [63:0]           r;
        logic [RADIX*N_IN-1:0] d;
        r = {$urandom(), $urandom()};
        d = r[RADIX*N_IN-1:0];
        for (int i = 0; i < int'(N_IN); i++) begin
            d[RADIX*i + 0] = 1'b0;
            d[RADIX*i + 2] = 1'b0;
            if (who[i]) d[RADIX*i + b] = 1'b1;
        end
        return d;
    endfunction

    task automatic clear_inputs();
        in_valid = '0;
        in_tail  = '0;
        out_full = 1'b0;
        fwd_dir  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        chk({tag, "_rst_grant_e"}, 32'(grant_e), 0);
        chk({tag, "_rst_pop_e"},   32'(pop_e),   0);
        chk({tag, "_rst_sel_e"},   32'(sel_e),   0);
        chk({tag, "_rst_ov_e"},    32'(ov_e),    0);
        chk({tag, "_rst_busy_e"},  32'(busy_e),  0);
        chk({tag, "_rst_grant_p"}, 32'(grant_p), 0);
        chk({tag, "_rst_busy_p"},  32'(busy_p),  0);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    // Consume expected winners as pops appear; each pop must follow a pop-free cycle
    task automatic run_sb(input string tag, input bit use_ip, input int unsigned budget);
        int unsigned      n;
        logic [N_IN-1:0]  p, g, prev_p;
        logic [SEL_W-1:0] s;
        logic [31:0]      e;
        n      = 0;
        prev_p = '0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            p = use_ip ? pop_p   : pop_e;
            g = use_ip ? grant_p : grant_e;
            s = use_ip ? sel_p   : sel_e;
            chk({tag, "_onehot0"},      32'($onehot0(g)), 1);
            chk({tag, "_pop_in_grant"}, 32'(p & ~g), 0);
            if (p != '0) begin
                e = exp_q.pop_front();
                chk({tag, "_winner"}, 32'(s), e);
                chk({tag, "_pop"},    32'(p), 32'(1) << e);
                chk({tag, "_bubble"}, 32'(prev_p), 0);
            end
            prev_p = p;
            n++;
            next_cycle();
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        // ---- 1: W sends a 3-flit packet to E ----
        do_reset("t1");
        in_valid = 7'b0000010;
        in_tail  = '0;
        fwd_dir  = dirs(7'b0000010, 2);
        @(negedge clk);
        chk("t1_idle_grant", 32'(grant_e), 0);
        chk("t1_idle_pop",   32'(pop_e),   0);
        next_cycle();
        @(negedge clk);
        chk("t1_grant", 32'(grant_e), 32'h02);
        chk("t1_sel",   32'(sel_e),   1);
        chk("t1_busy",  32'(busy_e),  1);
        chk("t1_pop1",  32'(pop_e),   32'h02);
        chk("t1_ov1",   32'(ov_e),    1);
        next_cycle();
        @(negedge clk);
        chk("t1_pop2", 32'(pop_e), 32'h02);
        next_cycle();
        in_tail = 7'b0000010;
        @(negedge clk);
        chk("t1_pop3", 32'(pop_e), 32'h02);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("t1_end_grant", 32'(grant_e), 0);
        chk("t1_end_busy",  32'(busy_e),  0);
        chk("t1_end_pop",   32'(pop_e),   0);

        // ---- 2: IP, N, U stream 1-flit packets to E ----
        do_reset("t2");
        in_valid = 7'b1010001;
        in_tail  = 7'b1010001;
        fwd_dir  = dirs(7'b1010001, 2);
`ifdef ARB_FIXED_PRIO_EN
        exp_q = '{0, 0, 0, 0, 0, 0};
`else
        exp_q = '{0, 4, 6, 0, 4, 6};
`endif
        run_sb("t2", 1'b0, 20);
        clear_inputs();

        // ---- 3: S locked, link full for 5 cycles, N waiting ----
        do_reset("t3");
        in_valid = 7'b0011000;
        in_tail  = '0;
        fwd_dir  = dirs(7'b0011000, 2);
        @(negedge clk);
        chk("t3_idle_grant", 32'(grant_e), 0);
        next_cycle();
        @(negedge clk);
        chk("t3_grant_s", 32'(grant_e), 32'h08);
        chk("t3_pop_s1",  32'(pop_e),   32'h08);
        next_cycle();
        out_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_full_pop",   32'(pop_e),   0);
            chk("t3_full_ov",    32'(ov_e),    0);
            chk("t3_full_grant", 32'(grant_e), 32'h08);
            next_cycle();
        end
        out_full = 1'b0;
        in_tail  = 7'b0001000;
        @(negedge clk);
        chk("t3_pop_tail", 32'(pop_e),   32'h08);
        chk("t3_hold_s",   32'(grant_e), 32'h08);
        next_cycle();
        in_valid = 7'b0010000;
        in_tail  = 7'b0010000;
        @(negedge clk);
        chk("t3_bubble_grant", 32'(grant_e), 0);
        chk("t3_bubble_busy",  32'(busy_e),  0);
        next_cycle();
        @(negedge clk);
        chk("t3_grant_n", 32'(grant_e), 32'h10);
        chk("t3_pop_n",   32'(pop_e),   32'h10);
        next_cycle();
        clear_inputs();

        // ---- 4: U-turn mask on E, loopback allowed on IP ----
        do_reset("t4");
        in_valid = 7'b0000100;
        in_tail  = 7'b0000100;
        fwd_dir  = dirs(7'b0000100, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_uturn_grant_e", 32'(grant_e), 0);
            chk("t4_uturn_busy_e",  32'(busy_e),  0);
            chk("t4_uturn_grant_p", 32'(grant_p), 0);
            next_cycle();
        end
        in_valid = 7'b0000001;
        in_tail  = 7'b0000001;
        fwd_dir  = dirs(7'b0000001, 0);
        @(negedge clk);
        chk("t4_ip_idle", 32'(grant_p), 0);
        next_cycle();
        @(negedge clk);
        chk("t4_ip_grant",   32'(grant_p), 32'h01);
        chk("t4_ip_pop",     32'(pop_p),   32'h01);
        chk("t4_ip_sel",     32'(sel_p),   0);
        chk("t4_ip_e_quiet", 32'(grant_e), 0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        chk("t4_ip_release", 32'(grant_p), 0);
        next_cycle();

        // ---- 5: asynchronous reset mid-packet ----
        do_reset("t5");
        in_valid = 7'b0010000;
        in_tail  = 7'b0010000;
        fwd_dir  = dirs(7'b0010000, 2);
        next_cycle();
        @(negedge clk);
        chk("t5_pop_n", 32'(pop_e), 32'h10);
        next_cycle();
        in_valid = 7'b1000000;
        in_tail  = '0;
        fwd_dir  = dirs(7'b1000000, 2);
        next_cycle();
        @(negedge clk);
        chk("t5_grant_u", 32'(grant_e), 32'h40);
        next_cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_grant", 32'(grant_e), 0);
        chk("t5_async_busy",  32'(busy_e),  0);
        chk("t5_async_pop",   32'(pop_e),   0);
        chk("t5_async_sel",   32'(sel_e),   0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 7'b1010001;
        in_tail  = 7'b1010001;
        fwd_dir  = dirs(7'b1010001, 2);
        next_cycle();
        @(negedge clk);
        chk("t5_fresh_sel",   32'(sel_e),   0);
        chk("t5_fresh_grant", 32'(grant_e), 32'h01);
        next_cycle();
        clear_inputs();

        // ---- 6: inputs 2 and 5 stream 1-flit packets to IP ----
        do_reset("t6");
        in_valid = 7'b0100100;
        in_tail  = 7'b0100100;
        fwd_dir  = dirs(7'b0100100, 0);
`ifdef ARB_FIXED_PRIO_EN
        exp_q = '{2, 2, 2, 2};
`else
        exp_q = '{2, 5, 2, 5};
`endif
        run_sb("t6", 1'b1, 16);
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
